bist_fail_log: RTL and testbench

- Consumer side of the BIST fail interface: records every fail pulse the MBIST datapath raises during a test session.
- Each record holds {address, expected data, actual data}; records go into a small first-word-fall-through FIFO.
- Software or the test port drains records through a valid/ready read interface.
- Also keeps a saturating fail counter, a sticky overflow flag and session status; sits beside the BIST top, fed by its fail, NbarT, address, pattern and RAM-output nets.

---
 rtl/bist_fail_log.sv | 192 +++++++++++++++++++
 tb/tb_bist_fail_log.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_fail_log.sv
// bist_fail_log: collects BIST compare failures for one test session.
// Each failure is stored as {address, expected, actual} in a small
// first-word-fall-through FIFO that is drained through a valid/ready port.
// A saturating fail counter, a sticky overflow flag and busy/done status
// are kept alongside the FIFO.
// A session starts on the rising edge of NbarT and ends on its falling edge.
// Optional feature macro: BIST_FAIL_LOG_DEDUP_EN. When it is defined, a failure
// at the same address as the most recently pushed record is counted but not
// stored again.
module bist_fail_log #(
   parameter int SIZE   = 6,
   parameter int LENGTH = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              NbarT,
   input  logic              fail,
   input  logic [SIZE-1:0]   address,
   input  logic [LENGTH-1:0] expected,
   input  logic [LENGTH-1:0] actual,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [SIZE-1:0]   rd_addr,
   output logic [LENGTH-1:0] rd_exp,
   output logic [LENGTH-1:0] rd_act,
   output logic [CNT_W-1:0]  fail_count,
   output logic              overflow,
   output logic              busy,
   output logic              done
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = SIZE + 2 * LENGTH;

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   state_t            state;
   logic              nbart_q;
   logic              rise;
   logic              fall;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [RW-1:0]     mem [DEPTH];
   logic [RW-1:0]     head;
   logic              full;
   logic              empty;
   logic              capture;
   logic              dup;
   logic              pop;
   logic              push;
   logic              drop;

   assign rise = NbarT & ~nbart_q;
   assign fall = ~NbarT & nbart_q;

   // The pointers carry one extra wrap bit, so full and empty can be told apart
   // even though the address bits match in both cases.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // The flush on a session start overrides any capture or pop in that cycle.
   assign capture = (state == ARMED) & NbarT & fail & ~rise;
   assign pop     = ~empty & rd_ready & ~rise;

`ifdef BIST_FAIL_LOG_DEDUP_EN
   logic              last_valid;
   logic [SIZE-1:0]   last_addr;

   assign dup = last_valid && (last_addr == address);

   // Remember the address of the last stored record; a session start forgets it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_valid <= 1'b0;
         last_addr  <= '0;
      end else if (rise) begin
         last_valid <= 1'b0;
      end else if (push) begin
         last_valid <= 1'b1;
         last_addr  <= address;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // A pop in the same cycle frees a slot, so a full FIFO can still accept the
   // new record. A deduplicated capture is neither stored nor counted as dropped.
   assign push = capture & ~dup & (~full | pop);
   assign drop = capture & ~dup & full & ~pop;

   // The head entry is shown directly from storage, and the outputs read zero
   // when the FIFO is empty.
   assign head     = mem[rd_ptr[AW-1:0]];
   assign rd_valid = ~empty;
   assign {rd_addr, rd_exp, rd_act} = empty ? {RW{1'b0}} : head;

   // Register NbarT once so its edges can be detected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nbart_q <= 1'b0;
      end else begin
         nbart_q <= NbarT;
      end
   end

   // Session FSM. busy and done are registered together with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= ARMED;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            ARMED: begin
               if (fall) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (rise) begin
                  state <= ARMED;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers. A session start flushes the FIFO by resetting both pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (rise) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Record storage. It needs no reset because the pointers decide which
   // entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {address, expected, actual};
      end
   end

   // Saturating fail counter and sticky overflow flag, both cleared at the
   // start of each session.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_count <= '0;
         overflow   <= 1'b0;
      end else if (rise) begin
         fail_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (capture && (fail_count != {CNT_W{1'b1}})) begin
            fail_count <= fail_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bist_fail_log.sv
// tb_bist_fail_log: directed bench for bist_fail_log. A queue-based session
// model predicts every output on each falling clock edge. Hand-computed
// literal checks pin down the model itself. A second instance with a 3-bit
// counter exercises counter saturation.
module tb_bist_fail_log;

   localparam int SIZE   = 6;
   localparam int LENGTH = 8;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        NbarT;
   logic        fail;
   logic [5:0]  address;
   logic [7:0]  expected;
   logic [7:0]  actual;
   logic        rd_ready;
   logic        rd_valid;
   logic [5:0]  rd_addr;
   logic [7:0]  rd_exp;
   logic [7:0]  rd_act;
   logic [9:0]  fail_count;
   logic        overflow;
   logic        busy;
   logic        done;
   logic        sat_valid;
   logic [5:0]  sat_addr;
   logic [7:0]  sat_exp;
   logic [7:0]  sat_act;
   logic [2:0]  sat_count;
   logic        sat_ovf;
   logic        sat_busy;
   logic        sat_done;

   int testsRun = 0;
   int testsFailed = 0;

   bist_fail_log #(.SIZE(SIZE), .LENGTH(LENGTH), .DEPTH(DEPTH), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .NbarT(NbarT), .fail(fail), .address(address),
      .expected(expected), .actual(actual), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_addr(rd_addr), .rd_exp(rd_exp), .rd_act(rd_act), .fail_count(fail_count),
      .overflow(overflow), .busy(busy), .done(done)
   );

   bist_fail_log #(.SIZE(SIZE), .LENGTH(LENGTH), .DEPTH(DEPTH), .CNT_W(3)) dutSat (
      .clk(clk), .rst(rst), .NbarT(NbarT), .fail(fail), .address(address),
      .expected(expected), .actual(actual), .rd_valid(sat_valid), .rd_ready(rd_ready),
      .rd_addr(sat_addr), .rd_exp(sat_exp), .rd_act(sat_act), .fail_count(sat_count),
      .overflow(sat_ovf), .busy(sat_busy), .done(sat_done)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // Behavioural model: the list of records, the session flags and the count
   // of fails seen, all updated from the inputs present at each rising edge.
   logic [21:0] mq[$];
   int          mCount;
   bit          mOvf;
   bit          mArmed;
   bit          mDone;
   bit          mPrevN;
   bit          mLastValid;
   logic [5:0]  mLast;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         mCount = 0;
         mOvf = 0;
         mArmed = 0;
         mDone = 0;
         mPrevN = 0;
         mLastValid = 0;
         mLast = '0;
      end else begin
         if (NbarT && !mPrevN) begin
            mq.delete();
            mCount = 0;
            mOvf = 0;
            mLastValid = 0;
            mArmed = 1;
            mDone = 0;
         end else begin
            if (mq.size() > 0 && rd_ready) begin
               void'(mq.pop_front());
            end
            if (mArmed && NbarT && fail) begin
               mCount = mCount + 1;
`ifdef BIST_FAIL_LOG_DEDUP_EN
               if (!(mLastValid && mLast == address)) begin
`else
               begin
`endif
                  if (mq.size() < DEPTH) begin
                     mq.push_back({address, expected, actual});
                     mLastValid = 1;
                     mLast = address;
                  end else begin
                     mOvf = 1;
                  end
               end
            end
            if (mArmed && !NbarT && mPrevN) begin
               mArmed = 0;
               mDone = 1;
            end
         end
         mPrevN = NbarT;
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      logic [21:0] head;
      head = (mq.size() > 0) ? mq[0] : 22'h0;
      checkOutput("rd_valid", int'(rd_valid), int'(mq.size() > 0));
      checkOutput("rd_addr", int'(rd_addr), int'(head[21:16]));
      checkOutput("rd_exp", int'(rd_exp), int'(head[15:8]));
      checkOutput("rd_act", int'(rd_act), int'(head[7:0]));
      checkOutput("fail_count", int'(fail_count), (mCount > 1023) ? 1023 : mCount);
      checkOutput("sat_count", int'(sat_count), (mCount > 7) ? 7 : mCount);
      checkOutput("overflow", int'(overflow), int'(mOvf));
      checkOutput("busy", int'(busy), int'(mArmed));
      checkOutput("done", int'(done), int'(mDone));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic n, input logic f, input logic [5:0] a,
                                input logic [7:0] e, input logic [7:0] r, input logic rdy);
      NbarT = n;
      fail = f;
      address = a;
      expected = e;
      actual = r;
      rd_ready = rdy;
      tick();
   endtask

   task automatic newSession();
      applyStimulus(1'b0, 1'b0, 6'h0, 8'h0, 8'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b0);
   endtask

   // Fail-safe bound so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1;
      NbarT = 1'b0;
      fail = 1'b0;
      address = '0;
      expected = '0;
      actual = '0;
      rd_ready = 1'b0;
      tick();
      tick();
      checkOutput("reset_valid", int'(rd_valid), 0);
      checkOutput("reset_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      // fail outside a session is ignored
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 6'h01, 8'h11, 8'h10, 1'b0);
      checkOutput("idle_count", int'(fail_count), 0);
      checkOutput("idle_valid", int'(rd_valid), 0);

      // single fail
      applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b0);
      checkOutput("armed_busy", int'(busy), 1);
      applyStimulus(1'b1, 1'b1, 6'h15, 8'hAA, 8'hA8, 1'b0);
      checkOutput("single_valid", int'(rd_valid), 1);
      checkOutput("single_addr", int'(rd_addr), 'h15);
      checkOutput("single_exp", int'(rd_exp), 'hAA);
      checkOutput("single_act", int'(rd_act), 'hA8);
      checkOutput("single_count", int'(fail_count), 1);
      applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b1);
      checkOutput("single_popped", int'(rd_valid), 0);

      // overflow: six fails into four entries
      newSession();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 6'(i), 8'(i + 8'h40), 8'(i), 1'b0);
      applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b0);
      checkOutput("ovf_count", int'(fail_count), 6);
      checkOutput("ovf_flag", int'(overflow), 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("ovf_order", int'(rd_addr), i);
         applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b1);
      end
      checkOutput("ovf_drained", int'(rd_valid), 0);

      // full FIFO with simultaneous push and pop
      newSession();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 6'(8'h10 + i), 8'h55, 8'h54, 1'b0);
      applyStimulus(1'b1, 1'b1, 6'h3F, 8'hC3, 8'h00, 1'b1);
      checkOutput("pp_ovf", int'(overflow), 0);
      checkOutput("pp_head", int'(rd_addr), 'h11);
      checkOutput("pp_count", int'(fail_count), 5);
      for (int i = 0; i < 4; i++) begin
         checkOutput("pp_order", int'(rd_addr), (i == 3) ? 'h3F : ('h11 + i));
         applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b1);
      end
      checkOutput("pp_drained", int'(rd_valid), 0);

      // session end and restart, with a pending pop and fail at the restart
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 6'(8'h30 + i), 8'h0F, 8'h0E, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'h0, 8'h0, 8'h0, 1'b0);
      checkOutput("end_done", int'(done), 1);
      checkOutput("end_busy", int'(busy), 0);
      applyStimulus(1'b0, 1'b1, 6'h2A, 8'h01, 8'h02, 1'b0);
      applyStimulus(1'b0, 1'b1, 6'h2B, 8'h01, 8'h02, 1'b0);
      checkOutput("end_count_held", int'(fail_count), 10);
      applyStimulus(1'b1, 1'b1, 6'h2C, 8'h01, 8'h02, 1'b1);
      checkOutput("restart_busy", int'(busy), 1);
      checkOutput("restart_count", int'(fail_count), 0);
      checkOutput("restart_ovf", int'(overflow), 0);
      checkOutput("restart_valid", int'(rd_valid), 0);

      // saturation of the narrow counter
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 6'(8'h20 + i), 8'hFF, 8'hFE, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b0);
      checkOutput("sat_wide", int'(fail_count), 9);
      checkOutput("sat_narrow", int'(sat_count), 7);

      // repeated address
      newSession();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 6'h07, 8'h99, 8'h98, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b0);
      checkOutput("dedup_count", int'(fail_count), 3);
      n = 0;
      for (int i = 0; i < 8 && rd_valid; i++) begin
         n++;
         applyStimulus(1'b1, 1'b0, 6'h0, 8'h0, 8'h0, 1'b1);
      end
`ifdef BIST_FAIL_LOG_DEDUP_EN
      checkOutput("dedup_records", n, 1);
`else
      checkOutput("dedup_records", n, 3);
`endif

      // reset in the middle of a session
      applyStimulus(1'b1, 1'b1, 6'h09, 8'h12, 8'h13, 1'b0);
      #3;
      rst = 1'b1;
      NbarT = 1'b0;
      fail = 1'b0;
      rd_ready = 1'b0;
      #1;
      checkOutput("midrst_valid", int'(rd_valid), 0);
      checkOutput("midrst_addr", int'(rd_addr), 0);
      checkOutput("midrst_count", int'(fail_count), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 6'h05, 8'h01, 8'h00, 1'b0);
      checkOutput("postrst_count", int'(fail_count), 0);
      checkOutput("postrst_valid", int'(rd_valid), 0);
      checkOutput("postrst_done", int'(done), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
